// File: rtl/stream_max_tracker_pkg.sv
// Shared types and width helpers for the streaming max/min tracker.
package stream_max_pkg;

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} smt_state_t;

  // Index width never drops to zero, even for a one-sample frame limit.
  function automatic int idx_w(input int max_len);
    return (max_len > 1) ? $clog2(max_len) : 1;
  endfunction

  function automatic int cnt_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/stream_max_tracker_cmp_sel.sv
// Combinational a>b compare with a selected winner; SEL_LOW picks the smaller operand.
module cmp_sel #(
  parameter int WIDTH   = 16,
  parameter bit SIGNED  = 1'b1,
  parameter bit SEL_LOW = 1'b0
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             flag,
  output logic [WIDTH-1:0] sel
);

  always_comb begin
    flag = SIGNED ? ($signed(a) > $signed(b)) : (a > b);
    sel  = (flag ^ SEL_LOW) ? a : b;
  end

endmodule

// File: rtl/stream_max_tracker.sv
// Per-frame running max/min/first-max-index over a valid/ready sample stream,
// presenting one held result per frame on a valid/ready output.
module stream_max_tracker
  import stream_max_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int MAX_LEN = 256,
  parameter bit SIGNED  = 1'b1,
  localparam int IDXW   = idx_w(MAX_LEN),
  localparam int CNTW   = cnt_w(MAX_LEN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_max,
  output logic [WIDTH-1:0] out_min,
  output logic [IDXW-1:0]  out_max_idx,
  output logic [CNTW-1:0]  out_count,
  output logic             out_trunc,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam logic [CNTW-1:0] LAST_CNT = CNTW'(MAX_LEN - 1);

  smt_state_t       state_q, state_d;
  logic [WIDTH-1:0] max_q, max_d, min_q, min_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;

  logic [WIDTH-1:0] out_max_q, out_max_d, out_min_q, out_min_d;
  logic [IDXW-1:0]  out_idx_q, out_idx_d;
  logic [CNTW-1:0]  out_cnt_q, out_cnt_d;
  logic             out_trunc_q, out_trunc_d;

  logic             in_fire, out_fire, close, trunc;
  logic             new_max, new_min;
  logic [WIDTH-1:0] max_sel, min_sel;

  // Strict compares: an equal sample never moves the max index.
  cmp_sel #(.WIDTH(WIDTH), .SIGNED(SIGNED), .SEL_LOW(1'b0)) u_max_cmp (
    .a(in_data), .b(max_q), .flag(new_max), .sel(max_sel)
  );

  cmp_sel #(.WIDTH(WIDTH), .SIGNED(SIGNED), .SEL_LOW(1'b1)) u_min_cmp (
    .a(min_q), .b(in_data), .flag(new_min), .sel(min_sel)
  );

  assign in_ready = (state_q != HOLD);
  assign out_valid = (state_q == HOLD);
  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_comb begin
    state_d     = state_q;
    max_d       = max_q;
    min_d       = min_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    close       = 1'b0;
    trunc       = 1'b0;
    out_max_d   = out_max_q;
    out_min_d   = out_min_q;
    out_idx_d   = out_idx_q;
    out_cnt_d   = out_cnt_q;
    out_trunc_d = out_trunc_q;

    case (state_q)
      IDLE: if (in_fire) begin
        max_d = in_data;
        min_d = in_data;
        idx_d = '0;
        cnt_d = CNTW'(1);
        if (in_last || MAX_LEN == 1) begin
          close = 1'b1;
          trunc = ~in_last;
        end else begin
          state_d = ACCUM;
        end
      end
      ACCUM: if (in_fire) begin
        max_d = max_sel;
        min_d = min_sel;
        if (new_max) idx_d = cnt_q[IDXW-1:0];
        cnt_d = cnt_q + CNTW'(1);
        // in_last wins over the length limit for the trunc flag.
        if (in_last || cnt_q == LAST_CNT) begin
          close = 1'b1;
          trunc = ~in_last;
        end
      end
      HOLD: if (out_fire) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (close) begin
      state_d     = HOLD;
      out_max_d   = max_d;
      out_min_d   = min_d;
      out_idx_d   = idx_d;
      out_cnt_d   = cnt_d;
      out_trunc_d = trunc;
    end
    // new_min only steers min_sel; keep it visibly consumed.
    if (new_min && state_q == IDLE) min_d = min_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      max_q       <= '0;
      min_q       <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      out_max_q   <= '0;
      out_min_q   <= '0;
      out_idx_q   <= '0;
      out_cnt_q   <= '0;
      out_trunc_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      max_q       <= max_d;
      min_q       <= min_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      out_max_q   <= out_max_d;
      out_min_q   <= out_min_d;
      out_idx_q   <= out_idx_d;
      out_cnt_q   <= out_cnt_d;
      out_trunc_q <= out_trunc_d;
    end
  end

  assign out_max     = out_max_q;
  assign out_min     = out_min_q;
  assign out_max_idx = out_idx_q;
  assign out_count   = out_cnt_q;
  assign out_trunc   = out_trunc_q;

endmodule

// File: tb/tb_stream_max_tracker.sv
// Drives a signed and an unsigned tracker with the same stream and checks both
// against a frame-level reference model.
module tb_stream_max_tracker;
  localparam int W    = 16;
  localparam int ML   = 8;
  localparam int IDXW = 3;
  localparam int CNTW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0] in_data = '0;
  logic in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;

  logic            s_in_ready, s_valid, s_trunc;
  logic [W-1:0]    s_max, s_min;
  logic [IDXW-1:0] s_idx;
  logic [CNTW-1:0] s_cnt;
  logic            u_in_ready, u_valid, u_trunc;
  logic [W-1:0]    u_max, u_min;
  logic [IDXW-1:0] u_idx;
  logic [CNTW-1:0] u_cnt;

  stream_max_tracker #(.WIDTH(W), .MAX_LEN(ML), .SIGNED(1'b1)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(s_in_ready), .out_max(s_max), .out_min(s_min), .out_max_idx(s_idx),
    .out_count(s_cnt), .out_trunc(s_trunc), .out_valid(s_valid), .out_ready(out_ready)
  );

  stream_max_tracker #(.WIDTH(W), .MAX_LEN(ML), .SIGNED(1'b0)) dut_u (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(u_in_ready), .out_max(u_max), .out_min(u_min), .out_max_idx(u_idx),
    .out_count(u_cnt), .out_trunc(u_trunc), .out_valid(u_valid), .out_ready(out_ready)
  );

  typedef struct {
    logic [15:0] mx;
    logic [15:0] mn;
    int          idx;
    int          cnt;
    bit          trunc;
  } res_t;

  res_t        exp_s[$], exp_u[$];
  logic [15:0] cur[$];
  int          checks = 0;
  int          errors = 0;
  bit          fired;

  function automatic bit greater(input logic [15:0] a, input logic [15:0] b, input bit sgn);
    return sgn ? ($signed(a) > $signed(b)) : (a > b);
  endfunction

  function automatic res_t ref_frame(input bit sgn, input bit trunc);
    res_t r;
    r.mx = cur[0]; r.mn = cur[0]; r.idx = 0; r.cnt = cur.size(); r.trunc = trunc;
    for (int i = 1; i < cur.size(); i++) begin
      if (greater(cur[i], r.mx, sgn)) begin r.mx = cur[i]; r.idx = i; end
      if (greater(r.mn, cur[i], sgn)) r.mn = cur[i];
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs();
    bit hold;
    hold = (exp_s.size() != 0);
    chk("s_in_ready", 32'(s_in_ready), 32'(!hold));
    chk("s_out_valid", 32'(s_valid), 32'(hold));
    chk("u_in_ready", 32'(u_in_ready), 32'(!hold));
    chk("u_out_valid", 32'(u_valid), 32'(hold));
    if (!rst_n) begin
      chk("rst_s_maxmin", {s_max, s_min}, 32'(0));
      chk("rst_u_maxmin", {u_max, u_min}, 32'(0));
      chk("rst_misc", 32'({s_idx, s_cnt, s_trunc, u_idx, u_cnt, u_trunc}), 32'(0));
    end
    if (hold) begin
      chk("s_max", 32'(s_max), 32'(exp_s[0].mx));
      chk("s_min", 32'(s_min), 32'(exp_s[0].mn));
      chk("s_idx", 32'(s_idx), 32'(exp_s[0].idx));
      chk("s_count", 32'(s_cnt), 32'(exp_s[0].cnt));
      chk("s_trunc", 32'(s_trunc), 32'(exp_s[0].trunc));
      chk("u_max", 32'(u_max), 32'(exp_u[0].mx));
      chk("u_min", 32'(u_min), 32'(exp_u[0].mn));
      chk("u_idx", 32'(u_idx), 32'(exp_u[0].idx));
      chk("u_count", 32'(u_cnt), 32'(exp_u[0].cnt));
      chk("u_trunc", 32'(u_trunc), 32'(exp_u[0].trunc));
    end
  endtask

  // One clock: check at negedge, advance the model by what fires at the next posedge.
  task automatic step();
    bit accept;
    @(negedge clk);
    check_outputs();
    fired = 1'b0;
    if (!rst_n) begin
      cur.delete(); exp_s.delete(); exp_u.delete();
    end else begin
      accept = (exp_s.size() == 0);
      if (!accept && out_ready) begin
        void'(exp_s.pop_front());
        void'(exp_u.pop_front());
      end
      if (accept && in_valid) begin
        fired = 1'b1;
        cur.push_back(in_data);
        if (in_last || cur.size() == ML) begin
          exp_s.push_back(ref_frame(1'b1, !in_last));
          exp_u.push_back(ref_frame(1'b0, !in_last));
          cur.delete();
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] d, input bit last);
    in_valid = 1'b1; in_data = d; in_last = last;
    fired = 1'b0;
    for (int n = 0; n < 40 && !fired; n++) step();
    chk("push_accepted", 32'(fired), 32'(1));
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  initial begin
    // Reset with a valid sample pending: nothing consumed, outputs zero.
    in_valid = 1'b1; in_data = 16'h0055; in_last = 1'b1;
    repeat (3) step();
    in_valid = 1'b0; in_last = 1'b0;
    rst_n = 1'b1;
    step();

    // in_last without in_valid is ignored.
    in_last = 1'b1;
    repeat (2) step();
    in_last = 1'b0;

    // Signed/unsigned frame with a tied max and the most negative value.
    push(16'd5, 0); push(16'hFFFD, 0); push(16'd7, 0); push(16'd7, 0); push(16'h8000, 1);
    chk("t2_valid_latency", 32'(s_valid), 32'(1));
    chk("t2_s_max", 32'(s_max), 32'h7);
    chk("t2_s_idx", 32'(s_idx), 32'd2);
    chk("t2_s_min", 32'(s_min), 32'h8000);
    chk("t2_s_count", 32'(s_cnt), 32'd5);
    chk("t2_u_max", 32'(u_max), 32'hFFFD);
    chk("t2_u_idx", 32'(u_idx), 32'd1);
    chk("t2_u_min", 32'(u_min), 32'h5);

    // Length-limited frame followed by the remainder.
    for (int i = 0; i < 8; i++) push(16'(i), 0);
    chk("t4_trunc", 32'(s_trunc), 32'd1);
    chk("t4_count", 32'(s_cnt), 32'd8);
    chk("t4_idx", 32'(s_idx), 32'd7);
    push(16'd8, 0); push(16'd9, 1);
    chk("t4b_max", 32'(s_max), 32'd9);
    chk("t4b_count", 32'(s_cnt), 32'd2);
    chk("t4b_trunc", 32'(s_trunc), 32'd0);

    // Limit reached together with in_last.
    for (int i = 0; i < 7; i++) push(16'(i + 100), 0);
    push(16'd3, 1);
    chk("lim_last_trunc", 32'(s_trunc), 32'd0);

    // Back-pressure: result held, upstream valid not consumed.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'h1234; in_last = 1'b1;
    repeat (5) step();
    out_ready = 1'b1;
    repeat (4) step();
    in_valid = 1'b0; in_last = 1'b0;
    repeat (2) step();

    // Random throttling with tie-prone data.
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(3) != 0);
      in_data   = ($urandom_range(1) == 0) ? 16'($urandom_range(7)) : 16'($urandom);
      in_last   = ($urandom_range(4) == 0);
      out_ready = ($urandom_range(2) != 0);
      step();
    end
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    repeat (4) step();

    // Reset mid-frame discards the partial frame.
    push(16'd40, 0); push(16'd41, 0); push(16'd42, 0);
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    repeat (2) step();
    push(16'hFFFF, 1);
    chk("t6_s_max", 32'(s_max), 32'hFFFF);
    chk("t6_s_min", 32'(s_min), 32'hFFFF);
    chk("t6_s_idx", 32'(s_idx), 32'd0);
    chk("t6_s_count", 32'(s_cnt), 32'd1);
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
